// File: rtl/exec_pkg.sv
// Shared execute-stage types for the multiply/divide unit: op and FSM state
// encodings plus the default datapath width.
package exec_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MUL   = 2'b00,
    MULHU = 2'b01,
    DIVU  = 2'b10,
    REMU  = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mdu_state_t;

  function automatic logic op_is_div(input mdu_op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One combinational iteration of the MDU: a shift-add multiply step or a
// restoring divide step on the shared 2*WIDTH accumulator.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div_i,
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_sh_s;
  logic [WIDTH:0] diff_s;

  always_comb begin
    sum_s    = {1'b0, acc_i[2*WIDTH-1:WIDTH]}
             + (acc_i[0] ? {1'b0, b_i} : {(WIDTH+1){1'b0}});
    rem_sh_s = acc_i[2*WIDTH-1:WIDTH-1];
    // rem_sh_s < 2*b, so the MSB of this WIDTH+1-bit difference is a clean borrow
    diff_s   = rem_sh_s - {1'b0, b_i};
    if (is_div_i) begin
      if (!diff_s[WIDTH]) begin
        acc_o = {diff_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_sh_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum_s, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Multi-cycle MUL/MULHU/DIVU/REMU unit beside the ALU: stalls the pipeline
// while iterating one bit per cycle, then strobes a registered result.
module mdu_sequencer
  import exec_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] result_o,
  output logic             valid_o,
  output logic             divzero_o
);

  mdu_state_t         state_q, state_d;
  mdu_op_t            op_q, op_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               valid_q, valid_d;
  logic               divzero_q, divzero_d;
  logic               stall_s;
  logic [2*WIDTH-1:0] step_acc_s;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i (op_is_div(op_q)),
    .acc_i    (acc_q),
    .b_i      (b_q),
    .acc_o    (step_acc_s)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      op_q      <= MUL;
      b_q       <= {WIDTH{1'b0}};
      acc_q     <= {(2*WIDTH){1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      result_q  <= {WIDTH{1'b0}};
      valid_q   <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      valid_q   <= valid_d;
      divzero_q <= divzero_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    valid_d   = 1'b0;
    divzero_d = 1'b0;
    stall_s   = 1'b0;
    case (state_q)
      IDLE: begin
        stall_s = start_i & ~flush_i;
        if (start_i && !flush_i) begin
          op_d  = mdu_op_t'(op_i);
          b_d   = b_i;
          acc_d = {{WIDTH{1'b0}}, a_i};
          cnt_d = {CNT_W{1'b0}};
          if (op_is_div(mdu_op_t'(op_i)) && (b_i == {WIDTH{1'b0}})) begin
            state_d   = DONE;
            valid_d   = 1'b1;
            divzero_d = 1'b1;
            result_d  = (op_i == DIVU) ? {WIDTH{1'b1}} : a_i;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        stall_s = ~flush_i;
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc_s;
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_d  = DONE;
            valid_d  = 1'b1;
            // MULHU and REMU live in the upper half, MUL and DIVU in the lower
            result_d = op_q[0] ? step_acc_s[2*WIDTH-1:WIDTH] : step_acc_s[WIDTH-1:0];
          end else begin
            state_d = RUN;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign stall_o   = stall_s & ~rst_i;
  assign busy_o    = (state_q != IDLE);
  assign result_o  = result_q;
  assign valid_o   = valid_q & ~flush_i;
  assign divzero_o = divzero_q & ~flush_i;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer with hand-computed results
// for multiply, divide, divide-by-zero, flush and asynchronous reset.
module tb_mdu_sequencer;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         flush_i;
  logic         stall_o;
  logic         busy_o;
  logic [W-1:0] result_o;
  logic         valid_o;
  logic         divzero_o;

  int vecs = 0;
  int errs = 0;

  mdu_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .op_i      (op_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .flush_i   (flush_i),
    .stall_o   (stall_o),
    .busy_o    (busy_o),
    .result_o  (result_o),
    .valid_o   (valid_o),
    .divzero_o (divzero_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Issue one op at cycle T, hold start through DONE, scramble operands mid-run.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp, input logic dz);
    int lat;
    lat     = dz ? 1 : W + 1;
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    #1;
    chk1({tag, " stall@T"}, stall_o, 1'b1);
    for (int k = 1; k < lat; k++) begin
      tick();
      if (k == 1) begin
        a_i  = ~a;
        b_i  = ~b;
        op_i = ~op;
      end
      #1;
      chk1({tag, " stall@run"}, stall_o, 1'b1);
      chk1({tag, " valid@run"}, valid_o, 1'b0);
    end
    tick();
    chk1({tag, " valid@done"}, valid_o, 1'b1);
    chk1({tag, " divzero@done"}, divzero_o, dz);
    chk({tag, " result@done"}, result_o, exp);
    chk1({tag, " stall@done"}, stall_o, 1'b0);
    tick();
    start_i = 1'b0;
    #1;
    chk1({tag, " valid@after"}, valid_o, 1'b0);
    chk1({tag, " busy@after"}, busy_o, 1'b0);
  endtask

  initial begin
    rst_i   = 1'b1;
    start_i = 1'b1;
    flush_i = 1'b0;
    op_i    = 2'b00;
    a_i     = 32'd7;
    b_i     = 32'd6;
    tick();
    tick();
    #1;
    chk1("reset stall", stall_o, 1'b0);
    chk1("reset busy", busy_o, 1'b0);
    chk1("reset valid", valid_o, 1'b0);
    chk1("reset divzero", divzero_o, 1'b0);
    chk("reset result", result_o, 32'h0000_0000);
    rst_i   = 1'b0;
    start_i = 1'b0;
    tick();

    run_op("MUL 7x6", 2'b00, 32'd7, 32'd6, 32'd42, 1'b0);
    run_op("MULHU ffx ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    run_op("MUL ffx ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("DIVU 100/7", 2'b10, 32'd100, 32'd7, 32'd14, 1'b0);
    run_op("REMU 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 1'b0);
    run_op("DIVU 5/0", 2'b10, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
    run_op("REMU 5/0", 2'b11, 32'd5, 32'd0, 32'd5, 1'b1);
    run_op("DIVU max/16", 2'b10, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 1'b0);
    run_op("REMU max/max-1", 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0);
    run_op("MULHU 2^16 sq", 2'b01, 32'h0001_0000, 32'h0001_0000, 32'd1, 1'b0);

    // Flush a divide at T+10, then a new multiply at T+12.
    start_i = 1'b1;
    op_i    = 2'b10;
    a_i     = 32'd100;
    b_i     = 32'd7;
    #1;
    chk1("flush stall@T", stall_o, 1'b1);
    repeat (10) tick();
    flush_i = 1'b1;
    #1;
    chk1("flush stall@T+10", stall_o, 1'b0);
    chk1("flush busy@T+10", busy_o, 1'b1);
    tick();
    flush_i = 1'b0;
    start_i = 1'b0;
    #1;
    chk1("flush busy@T+11", busy_o, 1'b0);
    chk1("flush valid@T+11", valid_o, 1'b0);
    tick();
    chk1("flush valid@T+12", valid_o, 1'b0);
    run_op("MUL 3x3 after flush", 2'b00, 32'd3, 32'd3, 32'd9, 1'b0);

    // Asynchronous reset in the middle of a multiply.
    start_i = 1'b1;
    op_i    = 2'b00;
    a_i     = 32'd11;
    b_i     = 32'd13;
    repeat (5) tick();
    rst_i = 1'b1;
    #1;
    chk1("midrst stall", stall_o, 1'b0);
    chk1("midrst busy", busy_o, 1'b0);
    chk1("midrst valid", valid_o, 1'b0);
    chk("midrst result", result_o, 32'h0000_0000);
    start_i = 1'b0;
    tick();
    rst_i = 1'b0;
    tick();
    chk1("postrst busy", busy_o, 1'b0);
    run_op("MUL 7x6 after rst", 2'b00, 32'd7, 32'd6, 32'd42, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
